// File: rtl/tie_lut_pipe.sv
// TIE lookup device model: writable table swept to a default value after reset or
// on request, serving lookups through a fixed-latency result pipeline.
module tie_lut_pipe #(
  parameter int          ADDR_W       = 8,
  parameter int          DATA_W       = 32,
  parameter int          LATENCY      = 1,
  parameter logic [31:0] DEFAULT_DATA = 32'hDEADBEEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] TIE_lut_Out,
  input  logic              TIE_lut_Out_Req,
  output logic [DATA_W-1:0] TIE_lut_In,
  output logic              TIE_lut_In_Vld,
  output logic              TIE_lut_Rdy,
  input  logic              Cfg_We,
  input  logic [ADDR_W-1:0] Cfg_Addr,
  input  logic [DATA_W-1:0] Cfg_Data,
  input  logic              Cfg_Clr,
  output logic              Cfg_Err
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [DATA_W-1:0] DEF_DATA = DATA_W'(DEFAULT_DATA);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $fatal(1, "tie_lut_pipe: LATENCY must be in 1..4");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q;
  logic [ADDR_W:0]   idx_q;
  logic              rdy_q;
  logic              err_q;
  logic [DATA_W-1:0] lut_mem [DEPTH];
  logic              vld_q [LATENCY];
  logic [DATA_W-1:0] dat_q [LATENCY];
  logic              accept;

  assign accept = TIE_lut_Out_Req && rdy_q;

  // Init/run sequencer; Rdy is kept as its own flop so the core sees a clean registered output.
  // NOTE: every sequential block uses non-blocking (<=) assignments so all flops sample
  // pre-edge values; blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= Cfg_We && (state_q == ST_INIT);
      case (state_q)
        ST_INIT: begin
          if (Cfg_Clr) begin
            idx_q <= '0;
          end else if (idx_q == LAST_IDX) begin
            state_q <= ST_RUN;
            rdy_q   <= 1'b1;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (Cfg_Clr) begin
            state_q <= ST_INIT;
            rdy_q   <= 1'b0;
            idx_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_INIT;
          rdy_q   <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // NOTE: the table has no reset branch on purpose; the init sweep overwrites it, and a
  // reset here would turn the array into thousands of resettable flops instead of memory.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      if (state_q == ST_INIT) begin
        lut_mem[idx_q[ADDR_W-1:0]] <= DEF_DATA;
      end else if (Cfg_We) begin
        lut_mem[Cfg_Addr] <= Cfg_Data;
      end
    end
  end

  // Result pipeline: data stages only load on a valid input so the last stage holds
  // the previous result, which is exactly the required TIE_lut_In behaviour.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= DEF_DATA;
      end
    end else begin
      vld_q[0] <= accept;
      if (accept) begin
        dat_q[0] <= lut_mem[TIE_lut_Out];
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign TIE_lut_In     = dat_q[LATENCY-1];
  assign TIE_lut_In_Vld = vld_q[LATENCY-1];
  assign TIE_lut_Rdy    = rdy_q;
  assign Cfg_Err        = err_q;

endmodule

// File: tb/tb_tie_lut_pipe.sv
// Self-checking bench for tie_lut_pipe: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_tie_lut_pipe;

  localparam int          ADDR_W = 8;
  localparam int          DATA_W = 32;
  localparam int          LAT    = 3;
  localparam logic [31:0] DEF    = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] lut_addr;
  logic              lut_req;
  logic [DATA_W-1:0] lut_data;
  logic              lut_vld;
  logic              lut_rdy;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_clr;
  logic              cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tie_lut_pipe #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT), .DEFAULT_DATA(DEF)
  ) dut (
    .CLK            (clk),
    .Reset          (rst),
    .TIE_lut_Out    (lut_addr),
    .TIE_lut_Out_Req(lut_req),
    .TIE_lut_In     (lut_data),
    .TIE_lut_In_Vld (lut_vld),
    .TIE_lut_Rdy    (lut_rdy),
    .Cfg_We         (cfg_we),
    .Cfg_Addr       (cfg_addr),
    .Cfg_Data       (cfg_data),
    .Cfg_Clr        (cfg_clr),
    .Cfg_Err        (cfg_err)
  );

  // Reference model: table contents, sweep progress, and a queue of results with due edges.
  typedef struct {
    int          due;
    logic [31:0] d;
  } res_t;

  logic [31:0] ref_mem [256];
  res_t        pend [$];
  bit          ref_rdy;
  int          ref_idx;
  bit          ref_err;
  bit          ref_vld;
  logic [31:0] ref_out;
  int          edge_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_edge();
    edge_no++;
    if (rst) begin
      pend.delete();
      ref_rdy = 1'b0;
      ref_idx = 0;
      ref_err = 1'b0;
      ref_vld = 1'b0;
      ref_out = DEF;
      return;
    end
    ref_err = cfg_we && !ref_rdy;
    if (lut_req && ref_rdy) pend.push_back('{edge_no + LAT - 1, ref_mem[lut_addr]});
    if (ref_rdy) begin
      if (cfg_we) ref_mem[cfg_addr] = cfg_data;
      if (cfg_clr) begin
        ref_rdy = 1'b0;
        ref_idx = 0;
      end
    end else begin
      ref_mem[ref_idx] = DEF;
      if (cfg_clr) ref_idx = 0;
      else if (ref_idx == 255) ref_rdy = 1'b1;
      else ref_idx++;
    end
    ref_vld = 1'b0;
    if (pend.size() > 0 && pend[0].due == edge_no) begin
      ref_vld = 1'b1;
      ref_out = pend[0].d;
      void'(pend.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_rdy", {31'd0, lut_rdy}, {31'd0, ref_rdy});
    check("model_vld", {31'd0, lut_vld}, {31'd0, ref_vld});
    check("model_data", lut_data, ref_out);
    check("model_err", {31'd0, cfg_err}, {31'd0, ref_err});
  endtask

  task automatic idle();
    lut_req = 1'b0;
    cfg_we  = 1'b0;
    cfg_clr = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic lookup_expect(input string tag, input logic [7:0] a, input logic [31:0] exp);
    lut_req = 1'b1; lut_addr = a;
    tick();
    lut_req = 1'b0;
    repeat (LAT - 1) tick();
    check({tag, "_vld"}, {31'd0, lut_vld}, 32'd1);
    check({tag, "_data"}, lut_data, exp);
    tick();
    check({tag, "_vld_end"}, {31'd0, lut_vld}, 32'd0);
    check({tag, "_hold"}, lut_data, exp);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 255) check({tag, "_rdy_low_255"}, {31'd0, lut_rdy}, 32'd0);
    end
    check({tag, "_rdy_high_256"}, {31'd0, lut_rdy}, 32'd1);
  endtask

  initial begin
    idle();
    lut_addr = '0; cfg_addr = '0; cfg_data = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_rdy", {31'd0, lut_rdy}, 32'd0);
    check("rst_vld", {31'd0, lut_vld}, 32'd0);
    check("rst_data", lut_data, DEF);
    check("rst_err", {31'd0, cfg_err}, 32'd0);
    rst = 1'b0;

    // Reset-to-ready time and swept default.
    wait_ready("init");
    lookup_expect("init_33", 8'h33, DEF);

    // Programmed lookup with latency.
    cfg_write(8'h11, 32'hCAFEBABE);
    lookup_expect("prog_11", 8'h11, 32'hCAFEBABE);

    // Back-to-back lookups.
    cfg_write(8'h00, 32'hFACEF00D);
    cfg_write(8'h33, 32'h33333333);
    cfg_write(8'hFF, 32'hFFFFFFFF);
    lut_req = 1'b1;
    lut_addr = 8'h00; tick();
    lut_addr = 8'h33; tick();
    lut_addr = 8'hFF; tick();
    lut_req = 1'b0;
    check("b2b_0_vld", {31'd0, lut_vld}, 32'd1);
    check("b2b_0_data", lut_data, 32'hFACEF00D);
    tick();
    check("b2b_1_vld", {31'd0, lut_vld}, 32'd1);
    check("b2b_1_data", lut_data, 32'h33333333);
    tick();
    check("b2b_2_vld", {31'd0, lut_vld}, 32'd1);
    check("b2b_2_data", lut_data, 32'hFFFFFFFF);
    tick();
    check("b2b_end_vld", {31'd0, lut_vld}, 32'd0);

    // Read-before-write collision.
    cfg_write(8'h22, 32'h22222222);
    cfg_we = 1'b1; cfg_addr = 8'h22; cfg_data = 32'h12345678;
    lut_req = 1'b1; lut_addr = 8'h22;
    tick();
    cfg_we = 1'b0;
    tick();
    lut_req = 1'b0;
    tick();
    check("coll_old_vld", {31'd0, lut_vld}, 32'd1);
    check("coll_old_data", lut_data, 32'h22222222);
    tick();
    check("coll_new_vld", {31'd0, lut_vld}, 32'd1);
    check("coll_new_data", lut_data, 32'h12345678);

    // Clear with two lookups in flight, plus a dropped write during the sweep.
    lut_req = 1'b1; lut_addr = 8'h11; tick();
    lut_addr = 8'h33; cfg_clr = 1'b1; tick();
    check("clr_rdy_low", {31'd0, lut_rdy}, 32'd0);
    idle();
    tick();
    check("clr_a_vld", {31'd0, lut_vld}, 32'd1);
    check("clr_a_data", lut_data, 32'hCAFEBABE);
    tick();
    check("clr_b_vld", {31'd0, lut_vld}, 32'd1);
    check("clr_b_data", lut_data, 32'h33333333);
    for (int i = 3; i <= 255; i++) begin
      if (i == 100) begin
        cfg_we = 1'b1; cfg_addr = 8'h05; cfg_data = 32'h0;
      end
      tick();
      cfg_we = 1'b0;
      if (i == 100) check("drop_err_pulse", {31'd0, cfg_err}, 32'd1);
      if (i == 101) check("drop_err_end", {31'd0, cfg_err}, 32'd0);
      if (i == 255) check("clr_rdy_low_255", {31'd0, lut_rdy}, 32'd0);
    end
    tick();
    check("clr_rdy_high_256", {31'd0, lut_rdy}, 32'd1);
    lookup_expect("drop_05", 8'h05, DEF);
    lookup_expect("clr_11", 8'h11, DEF);

    // Reset with the pipeline full.
    cfg_write(8'h00, 32'hFACEF00D);
    lut_req = 1'b1;
    lut_addr = 8'h00; tick();
    lut_addr = 8'h11; tick();
    lut_addr = 8'h00; rst = 1'b1; tick();
    check("mid_rst_vld", {31'd0, lut_vld}, 32'd0);
    check("mid_rst_data", lut_data, DEF);
    rst = 1'b0;
    idle();
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i <= LAT + 1) check("mid_rst_no_vld", {31'd0, lut_vld}, 32'd0);
      if (i == 255) check("mid_rst_rdy_low_255", {31'd0, lut_rdy}, 32'd0);
    end
    check("mid_rst_rdy_high_256", {31'd0, lut_rdy}, 32'd1);
    lookup_expect("mid_rst_00", 8'h00, DEF);

    // Randomized traffic with narrow addresses to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      lut_req  = 1'($urandom_range(0, 1));
      lut_addr = 8'($urandom_range(0, 15));
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_addr = 8'($urandom_range(0, 15));
      cfg_data = $urandom;
      cfg_clr  = ($urandom_range(0, 399) == 0);
      rst      = ($urandom_range(0, 1499) == 0);
      tick();
    end
    idle();
    rst = 1'b0;
    repeat (LAT + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tie_lut_pipe.md
# tie_lut_pipe

Parametrised TIE lookup device model for XTSC Verilog co-simulation. It serves the core's TIE lookup interface from a writable table of configurable depth and width, with a fixed programmable result latency. A side configuration port loads table contents at run time instead of hard-coding them. After reset, or on request, a built-in init sequencer sweeps every entry to a default value; the core is stalled through `TIE_lut_Rdy` while the sweep runs.

## Interface
- `ADDR_W`, 8, lookup address width; table depth is 2**ADDR_W.
- `DATA_W`, 32, lookup result width.
- `LATENCY`, 1, cycles from request acceptance to result; legal 1..4, other values are a fatal elaboration error.
- `DEFAULT_DATA`, 32'hDEADBEEF, value written by the init sweep; truncated or zero-extended to DATA_W.

Ports:
- `CLK` in 1: sole clock, all logic on posedge.
- `Reset` in 1: synchronous, active-high.
- `TIE_lut_Out` in ADDR_W: lookup address from the core.
- `TIE_lut_Out_Req` in 1: lookup request.
- `TIE_lut_In` out DATA_W: lookup result.
- `TIE_lut_In_Vld` out 1: one-cycle pulse marking a new result on `TIE_lut_In`.
- `TIE_lut_Rdy` out 1: device ready; a request is accepted only while high.
- `Cfg_We` in 1: table write strobe.
- `Cfg_Addr` in ADDR_W: table write address.
- `Cfg_Data` in DATA_W: table write data.
- `Cfg_Clr` in 1: one-cycle pulse that restarts the init sweep.
- `Cfg_Err` out 1: one-cycle pulse when a write is dropped.

## Operation
- Table: 2**ADDR_W x DATA_W registers.
- Sequencer has two states, INIT and RUN.
- INIT:
  - Index counter (ADDR_W+1 bits) starts at 0 and writes DEFAULT_DATA to one entry per cycle.
  - When the index reaches 2**ADDR_W-1 and that entry is written, the sequencer moves to RUN.
  - `TIE_lut_Rdy` = 0 throughout INIT.
- RUN:
  - `TIE_lut_Rdy` = 1.
  - A `Cfg_Clr` pulse returns the sequencer to INIT with the index at 0.
- Acceptance:
  - A request is accepted in a cycle where `TIE_lut_Out_Req` && `TIE_lut_Rdy`.
  - The table is read at that cycle's posedge, using that cycle's `TIE_lut_Out`.
  - While `TIE_lut_Out_Req` is low, `TIE_lut_Out` is ignored. This differs from the legacy model, which looked up every cycle.
- Result pipeline: LATENCY stages of {valid, data}. Stage 1 captures the table read; the last stage drives the outputs.
  - `TIE_lut_In` updates only when the last stage is valid; otherwise it holds its previous value.
  - `TIE_lut_In_Vld` equals the last-stage valid bit.
- Throughput: one request per cycle in RUN. The pipeline is not stalled by the core.
- Config writes:
  - `Cfg_We` in RUN writes `Cfg_Data` to `Cfg_Addr` at the posedge.
  - `Cfg_We` in INIT is dropped and pulses `Cfg_Err` on the next cycle.
- Write/read collision:
  - A same-cycle write and accepted lookup to the same address returns the OLD entry (read-before-write).
  - The new value is visible to lookups accepted in the following cycle.
- `Cfg_Clr` while lookups are in flight: in-flight results still complete with their captured data. The `Cfg_Clr` cycle itself accepts requests, since `TIE_lut_Rdy` is still 1 during it.
- `Cfg_Clr` during INIT restarts the sweep at index 0.
- Reset:
  - Clears every pipeline valid bit; in-flight results are discarded.
  - Forces INIT with the index at 0.
  - Table contents are not reset directly; the sweep overwrites them.

## Timing
- Values while and immediately after `Reset` is high:
  - `TIE_lut_In` = DEFAULT_DATA
  - `TIE_lut_In_Vld` = 0
  - `TIE_lut_Rdy` = 0
  - `Cfg_Err` = 0
- Cycle 0 is the first cycle with `Reset` low. The sweep writes entries 0 .. 2**ADDR_W-1 in cycles 0 .. 2**ADDR_W-1. `TIE_lut_Rdy` = 1 from cycle 2**ADDR_W.
- Request accepted at edge N → `TIE_lut_In`/`TIE_lut_In_Vld` valid in the cycle after edge N+LATENCY-1, i.e. LATENCY registered stages. LATENCY=1 reproduces the legacy single-register behaviour.
- `Cfg_Clr` sampled at edge N → `TIE_lut_Rdy` = 0 from cycle N+1 for exactly 2**ADDR_W cycles.
- `Cfg_Err` pulses for one cycle, in the cycle after the dropped write.

## Test plan
- Reset-to-ready time and init values (ADDR_W=8, LATENCY=1): release `Reset`.
  - `TIE_lut_Rdy` rises exactly 256 cycles after `Reset` falls.
  - Lookup 0x33 → `TIE_lut_In` = 0xDEADBEEF with one `TIE_lut_In_Vld` pulse.
- Programmed lookup with latency (LATENCY=3): write 0x11 = 0xCAFEBABE, then request 0x11.
  - Result 0xCAFEBABE with `TIE_lut_In_Vld`, 3 cycles after acceptance.
  - `TIE_lut_In` holds that value afterwards.
- Back-to-back lookups: program 0x00 = 0xFACEF00D, 0x33 = 0x33333333, 0xFF = 0xFFFFFFFF. Request 0x00, 0x33, 0xFF on consecutive cycles.
  - Three consecutive valid results in request order.
- Collision: 0x22 holds 0x22222222. Write 0x22 = 0x12345678 in the same cycle as a lookup of 0x22, then look up 0x22 again next cycle.
  - Results are 0x22222222, then 0x12345678.
- Clear and dropped write: pulse `Cfg_Clr` with 2 lookups in flight.
  - Both lookups complete with their pre-clear data.
  - `TIE_lut_Rdy` stays low for 256 cycles.
  - A `Cfg_We` issued during the sweep pulses `Cfg_Err` and does not modify the table.
- Reset mid-operation: assert `Reset` with the pipeline full.
  - No `TIE_lut_In_Vld` pulse follows.
  - `TIE_lut_In` = 0xDEADBEEF.
  - The init sweep restarts at index 0.
